phase_decoder: RTL

Consumer side of the processor phase bus. Samples the one-hot, overlap-capable 5-bit phase vector (p5..p1) each cycle and turns it into registered per-stage strobes for the datapath. Keeps a two-slot instruction shadow (fetch slot, execute slot) so overlapped phases act on the right instruction. Returns the halt request to the phase generator, and reports retired-instruction count and illegal-phase errors. Sits between the phase generator and the datapath/register-file control.

---
 rtl/phase_pkg.sv | 43 ++++
 rtl/instr_class.sv | 22 ++
 rtl/phase_decoder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/phase_pkg.sv
// Shared definitions for the phase bus: phase codes, opcode fields, legality check.
package phase_pkg;

    localparam int unsigned PH_W    = 5;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_W    = 4;

    typedef logic [PH_W-1:0] phase_t;

    // Phase codes as seen on {p5,p4,p3,p2,p1}
    localparam phase_t PH_IDLE = 5'b00000;
    localparam phase_t PH_P1   = 5'b00001;
    localparam phase_t PH_P2   = 5'b00010;
    localparam phase_t PH_P3   = 5'b00100;
    localparam phase_t PH_P4   = 5'b01000;
    localparam phase_t PH_P5   = 5'b10000;
    localparam phase_t PH_P3P1 = 5'b00101;
    localparam phase_t PH_P5P2 = 5'b10010;

    // Opcode field values in instr[7:4] when instr[15:14] == CLS_PREFIX
    localparam logic [OP_W-1:0] HLT_OP     = 4'b1111;
    localparam logic [OP_W-1:0] NOP_OP     = 4'b1110;
    localparam logic [1:0]      CLS_PREFIX = 2'b11;

    // Per-stage strobe bundle driven towards the datapath
    typedef struct packed {
        logic wb_en;
        logic alu_go;
        logic rf_read;
        logic dec_en;
        logic ir_load;
    } strobe_t;

    // True for the idle code, any single-hot code and the two permitted overlaps
    function automatic logic is_legal_phase(input phase_t ph);
        case (ph)
            PH_IDLE, PH_P1, PH_P2, PH_P3, PH_P4, PH_P5,
            PH_P3P1, PH_P5P2: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_class.sv
// Combinational classification of an instruction word into HLT / NOP.
module instr_class #(
    parameter logic [3:0] HLT_OP = phase_pkg::HLT_OP,
    parameter logic [3:0] NOP_OP = phase_pkg::NOP_OP
) (
    input  logic [15:0] i_word,
    output logic        o_is_hlt_c,
    output logic        o_is_nop_c
);

    import phase_pkg::CLS_PREFIX;

    logic w_cls_match;
    logic w_unused;

    // Only the class prefix and opcode field take part in the decode
    assign w_cls_match = (i_word[15:14] == CLS_PREFIX);
    assign o_is_hlt_c  = w_cls_match && (i_word[7:4] == HLT_OP);
    assign o_is_nop_c  = w_cls_match && (i_word[7:4] == NOP_OP);
    assign w_unused    = ^{i_word[13:8], i_word[3:0]};

endmodule

// File: rtl/phase_decoder.sv
// Phase-bus consumer: turns sampled phase bits into one-cycle registered stage
// strobes, shadows the fetch/execute instruction slots, and reports halt,
// retired count and illegal-phase status.
module phase_decoder #(
    parameter logic [3:0]  HLT_OP = phase_pkg::HLT_OP,
    parameter logic [3:0]  NOP_OP = phase_pkg::NOP_OP,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       phase,
    input  logic [15:0]      instr,
    output logic             ir_load,
    output logic             dec_en,
    output logic             rf_read,
    output logic             alu_go,
    output logic             wb_en,
    output logic [15:0]      ir_ex,
    output logic             halt,
    output logic             halted,
    output logic             phase_err,
    output logic [CNT_W-1:0] retired
);

    import phase_pkg::is_legal_phase;
    import phase_pkg::strobe_t;
    import phase_pkg::INSTR_W;

    logic [INSTR_W-1:0] r_ir;
    logic [INSTR_W-1:0] r_ir_ex;
    strobe_t            r_strb;
    logic               r_halt;
    logic               r_halted;
    logic               r_err;
    logic [CNT_W-1:0]   r_retired;

    logic w_legal;
    logic w_p1;
    logic w_p2;
    logic w_p3;
    logic w_p4;
    logic w_p5;
    logic w_ex_hlt;
    logic w_ex_nop;

    // Phase bits only act when the whole code is legal
    assign w_legal = is_legal_phase(phase);
    assign w_p1    = w_legal & phase[0];
    assign w_p2    = w_legal & phase[1];
    assign w_p3    = w_legal & phase[2];
    assign w_p4    = w_legal & phase[3];
    assign w_p5    = w_legal & phase[4];

    instr_class #(
        .HLT_OP (HLT_OP),
        .NOP_OP (NOP_OP)
    ) u_ex_class (
        .i_word     (r_ir_ex),
        .o_is_hlt_c (w_ex_hlt),
        .o_is_nop_c (w_ex_nop)
    );

    // Instruction slots; with p3+p1 the execute slot takes the old fetch slot
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ir    <= '0;
            r_ir_ex <= '0;
        end else begin
            if (w_p1) r_ir    <= instr;
            if (w_p3) r_ir_ex <= r_ir;
        end
    end

    // One-cycle stage strobes, writeback suppressed for HLT/NOP
    always_ff @(posedge clock) begin
        if (reset) begin
            r_strb <= '0;
        end else begin
            r_strb.ir_load <= w_p1;
            r_strb.dec_en  <= w_p2;
            r_strb.rf_read <= w_p3;
            r_strb.alu_go  <= w_p4;
            r_strb.wb_en   <= w_p5 & ~w_ex_hlt & ~w_ex_nop;
        end
    end

    // Halt pulse per p4 with HLT in execute; sticky status until the next fetch
    always_ff @(posedge clock) begin
        if (reset) begin
            r_halt   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_halt <= w_p4 & w_ex_hlt;
            if (w_p4 && w_ex_hlt) begin
                r_halted <= 1'b1;
            end else if (w_p1) begin
                r_halted <= 1'b0;
            end
        end
    end

    // Retired counter, one step per writeback phase including HLT/NOP
    always_ff @(posedge clock) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_p5) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    // Sticky illegal-phase flag, cleared only by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (!w_legal) begin
            r_err <= 1'b1;
        end
    end

    assign ir_load   = r_strb.ir_load;
    assign dec_en    = r_strb.dec_en;
    assign rf_read   = r_strb.rf_read;
    assign alu_go    = r_strb.alu_go;
    assign wb_en     = r_strb.wb_en;
    assign ir_ex     = r_ir_ex;
    assign halt      = r_halt;
    assign halted    = r_halted;
    assign phase_err = r_err;
    assign retired   = r_retired;

endmodule
